// File: rtl/sleep_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sleep_sched_pkg
// Brief    : Shared state encoding and stats widths for the sleep scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sleep_sched_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RUN       = 3'd1,
        ST_IDLE_WAIT = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_SLEEP     = 3'd4,
        ST_WAKE      = 3'd5
    } state_t;

    localparam int STATS_CYC_W = 32;
    localparam int STATS_CNT_W = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sleep_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin grant holder; one zero-grant cycle between grantees.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk_ungated_i,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       en,
    input  logic                       release_gnt,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] ptr
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] r_gnt;
    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_src;
    logic [NUM_REQ-1:0] w_pick;
    logic [PTR_W-1:0]   w_next_ptr;

    // Requests at or above the pointer take precedence; otherwise wrap to the lowest.
    always_comb begin
        w_mask     = '0;
        w_next_ptr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (PTR_W'(i) >= r_ptr);
            if (r_gnt[i]) begin
                w_next_ptr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
        w_src  = (|(req & w_mask)) ? (req & w_mask) : req;
        w_pick = w_src & (~w_src + NUM_REQ'(1));
    end

    always_ff @(posedge clk_ungated_i or negedge resetn) begin
        if (!resetn) begin
            r_gnt <= '0;
            r_ptr <= '0;
        end else if (|r_gnt) begin
            if (release_gnt) begin
                r_gnt <= '0;
                r_ptr <= w_next_ptr;
            end else if (!en) begin
                r_gnt <= '0;
            end
        end else if (en) begin
            r_gnt <= w_pick;
        end
    end

    assign gnt = r_gnt;
    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/sleep_sched.sv
`default_nettype none
// ============================================================================
// Module   : sleep_sched
// Brief    : Core clock-gate power-state scheduler with drain handshake and
//            round-robin service grant. SLEEP_SCHED_STATS_EN adds sleep stats.
// Revision : 1.0 - initial release
// ============================================================================
module sleep_sched
    import sleep_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDLE_CYCLES = 38,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                   clk_ungated_i,
    input  logic                   resetn,
    input  logic                   fetch_enable_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic                   core_idle_i,
    input  logic                   drain_ack_i,
    output logic                   drain_req_o,
    output logic                   clock_en_o,
    output logic                   core_sleep_o,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [2:0]             state_o,
    output logic [STATS_CYC_W-1:0] sleep_cycles_o,
    output logic [STATS_CNT_W-1:0] sleep_count_o
);

    localparam int MAX_CYC = max_int(IDLE_CYCLES, WAKE_CYCLES);
    localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
    localparam int PTR_W   = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0] c_idle_last = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_wake_last = CNT_W'(WAKE_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_fetch_en;
    logic               w_any_req;
    logic               w_release;
    logic [PTR_W-1:0]   w_unused_ptr;

    assign w_any_req = |req_i;
    assign w_release = |(gnt_o & ~req_i);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:       if (fetch_enable_i || r_fetch_en) w_state_nxt = ST_RUN;
            ST_RUN:       if (!w_any_req && core_idle_i)    w_state_nxt = ST_IDLE_WAIT;
            ST_IDLE_WAIT: begin
                if (w_any_req || !core_idle_i) w_state_nxt = ST_RUN;
                else if (r_cnt == c_idle_last) w_state_nxt = ST_DRAIN;
            end
            // A request beats a same-cycle drain acknowledge.
            ST_DRAIN: begin
                if (w_any_req)        w_state_nxt = ST_RUN;
                else if (drain_ack_i) w_state_nxt = ST_SLEEP;
            end
            ST_SLEEP:     if (w_any_req)             w_state_nxt = ST_WAKE;
            ST_WAKE:      if (r_cnt == c_wake_last)  w_state_nxt = ST_RUN;
            default:      w_state_nxt = ST_OFF;
        endcase

        // One counter serves both IDLE_WAIT and WAKE; any transition restarts it.
        w_cnt_nxt = '0;
        if (w_state_nxt == r_state &&
            (r_state == ST_IDLE_WAIT || r_state == ST_WAKE)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_ungated_i or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_OFF;
            r_cnt      <= '0;
            r_fetch_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fetch_en <= r_fetch_en | fetch_enable_i;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk_ungated_i (clk_ungated_i),
        .resetn        (resetn),
        .req           (req_i),
        .en            (r_state == ST_RUN),
        .release_gnt   (w_release),
        .gnt           (gnt_o),
        .ptr           (w_unused_ptr)
    );

    assign state_o      = r_state;
    assign drain_req_o  = (r_state == ST_DRAIN);
    assign core_sleep_o = (r_state == ST_SLEEP);
    assign clock_en_o   = (r_state == ST_RUN) || (r_state == ST_IDLE_WAIT) ||
                          (r_state == ST_DRAIN) || (r_state == ST_WAKE);

`ifdef SLEEP_SCHED_STATS_EN
    logic [STATS_CYC_W-1:0] r_sleep_cycles;
    logic [STATS_CNT_W-1:0] r_sleep_count;

    always_ff @(posedge clk_ungated_i or negedge resetn) begin
        if (!resetn) begin
            r_sleep_cycles <= '0;
            r_sleep_count  <= '0;
        end else begin
            if (r_state == ST_SLEEP && !(&r_sleep_cycles)) begin
                r_sleep_cycles <= r_sleep_cycles + STATS_CYC_W'(1);
            end
            if (r_state == ST_DRAIN && w_state_nxt == ST_SLEEP && !(&r_sleep_count)) begin
                r_sleep_count <= r_sleep_count + STATS_CNT_W'(1);
            end
        end
    end

    assign sleep_cycles_o = r_sleep_cycles;
    assign sleep_count_o  = r_sleep_count;
`else
    assign sleep_cycles_o = '0;
    assign sleep_count_o  = '0;
`endif

endmodule
`default_nettype wire
